// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: opcodes, FSM states,
// and the select/function codes the datapath decodes.
package riscv_ctrl_pkg;

    // Major opcodes (instr[6:0]) recognised by the controller
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    // Branch conditions (funct3 of B-type)
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    // ALU operation funct3 values
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    // Controller states; encodings 13..15 are unused and recover to FETCH
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JALRADR  = 4'd10,
        S_JAL      = 4'd11,
        S_LUI      = 4'd12
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b100,
        ALU_XOR = 3'b101
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'd0,
        RES_DATA   = 2'd1,
        RES_ALURES = 2'd2,
        RES_IMM    = 2'd3
    } result_src_e;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'd0,
        SRCA_OLDPC = 2'd1,
        SRCA_A     = 2'd2,
        SRCA_ZERO  = 2'd3
    } src_a_e;

    typedef enum logic [1:0] {
        SRCB_B    = 2'd0,
        SRCB_IMM  = 2'd1,
        SRCB_FOUR = 2'd2,
        SRCB_ZERO = 2'd3
    } src_b_e;

    // Branch decision from the flags of the SUB performed in BRANCH
    function automatic logic branch_taken(input logic [2:0] f3,
                                          input logic       zero,
                                          input logic       neg);
        case (f3)
            F3_BEQ:  return zero;
            F3_BNE:  return ~zero;
            F3_BLT:  return neg;
            F3_BGE:  return ~neg;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU function decode from funct3, funct7[5] and instruction class.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [2:0] f3,
    input  logic       f7_5,
    input  logic       is_rtype,
    output alu_ctrl_e  alu_ctrl
);

    // funct7[5] selects SUB only for register-register ops; addi ignores it
    always_comb begin
        case (f3)
            F3_ADD:  alu_ctrl = (is_rtype && f7_5) ? ALU_SUB : ALU_ADD;
            F3_AND:  alu_ctrl = ALU_AND;
            F3_OR:   alu_ctrl = ALU_OR;
            F3_SLT:  alu_ctrl = ALU_SLT;
            F3_XOR:  alu_ctrl = ALU_XOR;
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore controller sequencing the shared-ALU multicycle RV32I datapath.
// One instruction in flight; FETCH -> DECODE -> class-specific states.
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opc,
    input  logic [2:0] f3,
    input  logic [6:0] f7,
    input  logic       zero,
    input  logic       neg,
    output logic       PCWrite,
    output logic       adrSrc,
    output logic       memWrite,
    output logic       IRWrite,
    output logic       regWrite,
    output logic [1:0] resultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] immSrc
);

    state_e      state_q, state_d;
    alu_ctrl_e   dec_alu_ctrl;

    logic        pc_write_c, adr_src_c, mem_write_c, ir_write_c, reg_write_c;
    result_src_e result_src_c;
    src_a_e      src_a_c;
    src_b_e      src_b_c;
    alu_ctrl_e   alu_ctrl_c;
    imm_src_e    imm_src_c;

    // Only funct7[5] matters to this ISA subset
    logic f7_unused;
    assign f7_unused = ^{f7[6], f7[4:0]};

    alu_decoder u_alu_decoder (
        .f3       (f3),
        .f7_5     (f7[5]),
        .is_rtype (opc == OPC_R),
        .alu_ctrl (dec_alu_ctrl)
    );

    // State register; reset returns to FETCH immediately
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples the pre-edge value of the others.
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Next-state logic; unused encodings and unknown opcodes fall back to FETCH
    always_comb begin
        // NOTE: default assigned first so no path leaves state_d unassigned,
        // which would otherwise infer a latch.
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                case (opc)
                    OPC_LOAD, OPC_STORE: state_d = S_MEMADR;
                    OPC_R:               state_d = S_EXECR;
                    OPC_I:               state_d = S_EXECI;
                    OPC_BRANCH:          state_d = S_BRANCH;
                    OPC_JAL:             state_d = S_JAL;
                    OPC_JALR:            state_d = S_JALRADR;
                    OPC_LUI:             state_d = S_LUI;
                    default:             state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (opc == OPC_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JALRADR:  state_d = S_JAL;
            S_JAL:      state_d = S_ALUWB;
            S_LUI:      state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Per-state datapath controls; each state overrides only what it needs
    always_comb begin
        pc_write_c   = 1'b0;
        adr_src_c    = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        result_src_c = RES_ALUOUT;
        src_a_c      = SRCA_PC;
        src_b_c      = SRCB_B;
        alu_ctrl_c   = ALU_ADD;
        imm_src_c    = IMM_I;
        case (state_q)
            S_FETCH: begin
                // PC+4 goes straight from the ALU into PC while IR loads
                ir_write_c   = 1'b1;
                pc_write_c   = 1'b1;
                src_b_c      = SRCB_FOUR;
                result_src_c = RES_ALURES;
            end
            S_DECODE: begin
                // Speculatively compute OldPC+imm as the branch/jal target
                src_a_c   = SRCA_OLDPC;
                src_b_c   = SRCB_IMM;
                imm_src_c = (opc == OPC_JAL) ? IMM_J : IMM_B;
            end
            S_MEMADR: begin
                src_a_c   = SRCA_A;
                src_b_c   = SRCB_IMM;
                imm_src_c = (opc == OPC_STORE) ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                adr_src_c = 1'b1;
            end
            S_MEMWB: begin
                result_src_c = RES_DATA;
                reg_write_c  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src_c   = 1'b1;
                mem_write_c = 1'b1;
            end
            S_EXECR: begin
                src_a_c    = SRCA_A;
                alu_ctrl_c = dec_alu_ctrl;
            end
            S_EXECI: begin
                src_a_c    = SRCA_A;
                src_b_c    = SRCB_IMM;
                alu_ctrl_c = dec_alu_ctrl;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
            end
            S_BRANCH: begin
                // Compare A-B; PC loads the target already held in ALUOut
                src_a_c    = SRCA_A;
                alu_ctrl_c = ALU_SUB;
                pc_write_c = branch_taken(f3, zero, neg);
            end
            S_JALRADR: begin
                src_a_c   = SRCA_A;
                src_b_c   = SRCB_IMM;
                imm_src_c = IMM_I;
            end
            S_JAL: begin
                // PC takes the target from ALUOut while the ALU forms OldPC+4
                pc_write_c = 1'b1;
                src_a_c    = SRCA_OLDPC;
                src_b_c    = SRCB_FOUR;
            end
            S_LUI: begin
                imm_src_c    = IMM_U;
                result_src_c = RES_IMM;
                reg_write_c  = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are cut combinationally by reset so no partial write can occur
    assign PCWrite    = pc_write_c  & ~rst;
    assign IRWrite    = ir_write_c  & ~rst;
    assign regWrite   = reg_write_c & ~rst;
    assign memWrite   = mem_write_c & ~rst;
    assign adrSrc     = adr_src_c;
    assign resultSrc  = result_src_c;
    assign ALUSrcA    = src_a_c;
    assign ALUSrcB    = src_b_c;
    assign ALUControl = alu_ctrl_c;
    assign immSrc     = imm_src_c;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle vector table for
// every instruction class plus hand sequences around reset.
module tb_multicycle_controller;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       irw;
        logic       regw;
        logic [1:0] rs;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [2:0] aluc;
        logic [2:0] imm;
    } ctrl_t;

    typedef struct {
        logic [8*8-1:0] tag;
        int             cyc;
        logic [6:0]     opc;
        logic [2:0]     f3;
        logic [6:0]     f7;
        logic           zero;
        logic           neg;
        ctrl_t          exp;
    } vec_t;

    // Hand-derived expected control words per state
    localparam ctrl_t E_RST      = '{rs:2'd2, srcb:2'd2, default:0};
    localparam ctrl_t E_FETCH    = '{pcw:1'b1, irw:1'b1, rs:2'd2, srcb:2'd2, default:0};
    localparam ctrl_t E_DEC_B    = '{srca:2'd1, srcb:2'd1, imm:3'd2, default:0};
    localparam ctrl_t E_DEC_J    = '{srca:2'd1, srcb:2'd1, imm:3'd3, default:0};
    localparam ctrl_t E_MADR_I   = '{srca:2'd2, srcb:2'd1, imm:3'd0, default:0};
    localparam ctrl_t E_MADR_S   = '{srca:2'd2, srcb:2'd1, imm:3'd1, default:0};
    localparam ctrl_t E_MEMREAD  = '{adr:1'b1, default:0};
    localparam ctrl_t E_MEMWB    = '{rs:2'd1, regw:1'b1, default:0};
    localparam ctrl_t E_MEMWRITE = '{adr:1'b1, memw:1'b1, default:0};
    localparam ctrl_t E_EXECR    = '{srca:2'd2, default:0};
    localparam ctrl_t E_EXECI    = '{srca:2'd2, srcb:2'd1, default:0};
    localparam ctrl_t E_ALUWB    = '{regw:1'b1, default:0};
    localparam ctrl_t E_BR_NT    = '{srca:2'd2, aluc:3'd1, default:0};
    localparam ctrl_t E_BR_T     = '{pcw:1'b1, srca:2'd2, aluc:3'd1, default:0};
    localparam ctrl_t E_JALRADR  = '{srca:2'd2, srcb:2'd1, imm:3'd0, default:0};
    localparam ctrl_t E_JAL      = '{pcw:1'b1, srca:2'd1, srcb:2'd2, default:0};
    localparam ctrl_t E_LUI      = '{imm:3'd4, rs:2'd3, regw:1'b1, default:0};

    logic       clk;
    logic       rst;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       zero;
    logic       neg;
    logic       PCWrite, adrSrc, memWrite, IRWrite, regWrite;
    logic [1:0] resultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ALUControl, immSrc;
    ctrl_t      act;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[$];

    multicycle_controller dut (
        .clk        (clk),
        .rst        (rst),
        .opc        (opc),
        .f3         (f3),
        .f7         (f7),
        .zero       (zero),
        .neg        (neg),
        .PCWrite    (PCWrite),
        .adrSrc     (adrSrc),
        .memWrite   (memWrite),
        .IRWrite    (IRWrite),
        .regWrite   (regWrite),
        .resultSrc  (resultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .immSrc     (immSrc)
    );

    assign act = {PCWrite, adrSrc, memWrite, IRWrite, regWrite,
                  resultSrc, ALUSrcA, ALUSrcB, ALUControl, immSrc};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctrl_t with_alu(input ctrl_t base, input logic [2:0] a);
        ctrl_t r;
        r = base;
        r.aluc = a;
        return r;
    endfunction

    task automatic check(input logic [8*8-1:0] tag, input int cyc,
                         input ctrl_t got, input ctrl_t want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %0s cycle %0d: got %05h required %05h", tag, cyc, got, want);
        end
    endtask

    task automatic add(input logic [8*8-1:0] tag, input logic [6:0] o,
                       input logic [2:0] fn3, input logic [6:0] fn7,
                       input logic z, input logic n, input ctrl_t e);
        vec_t v;
        int   c;
        c = 1;
        for (int i = vecs.size() - 1; i >= 0 && vecs[i].tag == tag; i--) c++;
        v.tag = tag; v.cyc = c; v.opc = o; v.f3 = fn3; v.f7 = fn7;
        v.zero = z; v.neg = n; v.exp = e;
        vecs.push_back(v);
    endtask

    // Drive one cycle's inputs, check mid-cycle, then advance past the edge
    task automatic apply(input vec_t v);
        opc = v.opc; f3 = v.f3; f7 = v.f7; zero = v.zero; neg = v.neg;
        #1;
        check(v.tag, v.cyc, act, v.exp);
        @(posedge clk);
        #1;
    endtask

    // Three-cycle branch: FETCH, DECODE, BRANCH with given flags
    task automatic add_br(input logic [8*8-1:0] tag, input logic [2:0] fn3,
                          input logic z, input logic n, input ctrl_t e3);
        add(tag, 7'b1100011, fn3, 7'd0, z, n, E_FETCH);
        add(tag, 7'b1100011, fn3, 7'd0, z, n, E_DEC_B);
        add(tag, 7'b1100011, fn3, 7'd0, z, n, e3);
    endtask

    task automatic add_r(input logic [8*8-1:0] tag, input logic [6:0] o,
                         input logic [2:0] fn3, input logic [6:0] fn7,
                         input ctrl_t e3);
        add(tag, o, fn3, fn7, 1'b0, 1'b0, E_FETCH);
        add(tag, o, fn3, fn7, 1'b0, 1'b0, E_DEC_B);
        add(tag, o, fn3, fn7, 1'b0, 1'b0, e3);
        add(tag, o, fn3, fn7, 1'b0, 1'b0, E_ALUWB);
    endtask

    initial begin
        // ---------------- vector table ----------------
        // lw: 5 cycles, regWrite only in MEMWB
        add("lw", 7'b0000011, 3'b010, 7'd0, 0, 0, E_FETCH);
        add("lw", 7'b0000011, 3'b010, 7'd0, 0, 0, E_DEC_B);
        add("lw", 7'b0000011, 3'b010, 7'd0, 0, 0, E_MADR_I);
        add("lw", 7'b0000011, 3'b010, 7'd0, 0, 0, E_MEMREAD);
        add("lw", 7'b0000011, 3'b010, 7'd0, 0, 0, E_MEMWB);
        // sw: 4 cycles, memWrite only in MEMWRITE
        add("sw", 7'b0100011, 3'b010, 7'd0, 0, 0, E_FETCH);
        add("sw", 7'b0100011, 3'b010, 7'd0, 0, 0, E_DEC_B);
        add("sw", 7'b0100011, 3'b010, 7'd0, 0, 0, E_MADR_S);
        add("sw", 7'b0100011, 3'b010, 7'd0, 0, 0, E_MEMWRITE);
        // R-type ALU map
        add_r("r_sub",  7'b0110011, 3'b000, 7'b0100000, with_alu(E_EXECR, 3'b001));
        add_r("r_add",  7'b0110011, 3'b000, 7'b0000000, with_alu(E_EXECR, 3'b000));
        add_r("r_and",  7'b0110011, 3'b111, 7'b0000000, with_alu(E_EXECR, 3'b010));
        add_r("r_slt",  7'b0110011, 3'b010, 7'b0000000, with_alu(E_EXECR, 3'b100));
        add_r("r_or",   7'b0110011, 3'b110, 7'b0000000, with_alu(E_EXECR, 3'b011));
        add_r("r_f3_1", 7'b0110011, 3'b001, 7'b0100000, with_alu(E_EXECR, 3'b000));
        // I-type: funct7[5] must not turn addi into SUB
        add_r("i_add",  7'b0010011, 3'b000, 7'b0100000, with_alu(E_EXECI, 3'b000));
        add_r("i_xor",  7'b0010011, 3'b100, 7'b0000000, with_alu(E_EXECI, 3'b101));
        // Branches
        add_br("beq_t",  3'b000, 1'b1, 1'b0, E_BR_T);
        add_br("beq_nt", 3'b000, 1'b0, 1'b0, E_BR_NT);
        add_br("bge_t",  3'b101, 1'b0, 1'b0, E_BR_T);
        add_br("bge_nt", 3'b101, 1'b0, 1'b1, E_BR_NT);
        add_br("bne_nt", 3'b001, 1'b1, 1'b0, E_BR_NT);
        add_br("blt_t",  3'b100, 1'b0, 1'b1, E_BR_T);
        add_br("bf3_2",  3'b010, 1'b1, 1'b1, E_BR_NT);
        // jal: 4 cycles
        add("jal", 7'b1101111, 3'b000, 7'd0, 0, 0, E_FETCH);
        add("jal", 7'b1101111, 3'b000, 7'd0, 0, 0, E_DEC_J);
        add("jal", 7'b1101111, 3'b000, 7'd0, 0, 0, E_JAL);
        add("jal", 7'b1101111, 3'b000, 7'd0, 0, 0, E_ALUWB);
        // jalr: 5 cycles
        add("jalr", 7'b1100111, 3'b000, 7'd0, 0, 0, E_FETCH);
        add("jalr", 7'b1100111, 3'b000, 7'd0, 0, 0, E_DEC_B);
        add("jalr", 7'b1100111, 3'b000, 7'd0, 0, 0, E_JALRADR);
        add("jalr", 7'b1100111, 3'b000, 7'd0, 0, 0, E_JAL);
        add("jalr", 7'b1100111, 3'b000, 7'd0, 0, 0, E_ALUWB);
        // lui: 3 cycles
        add("lui", 7'b0110111, 3'b000, 7'd0, 0, 0, E_FETCH);
        add("lui", 7'b0110111, 3'b000, 7'd0, 0, 0, E_DEC_B);
        add("lui", 7'b0110111, 3'b000, 7'd0, 0, 0, E_LUI);
        // unknown opcode: 2 cycles, then a fresh fetch
        add("unk", 7'b1111111, 3'b000, 7'd0, 0, 0, E_FETCH);
        add("unk", 7'b1111111, 3'b000, 7'd0, 0, 0, E_DEC_B);
        add("after", 7'b0110111, 3'b000, 7'd0, 0, 0, E_FETCH);

        // ---------------- reset state ----------------
        rst = 1'b1; opc = 7'b0000011; f3 = 3'd0; f7 = 7'd0; zero = 1'b0; neg = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset", 0, act, E_RST);
        rst = 1'b0;

        // ---------------- table ----------------
        foreach (vecs[i]) apply(vecs[i]);

        // ---------------- reset during MEMWRITE ----------------
        // The table ended inside a FETCH; restart cleanly first
        rst = 1'b1;
        #1;
        check("rst_fch", 0, act, E_RST);
        @(posedge clk);
        #1;
        rst = 1'b0;
        opc = 7'b0100011; f3 = 3'b010; f7 = 7'd0;
        #1;
        check("mw_fch", 1, act, E_FETCH);
        @(posedge clk); #1;
        #1;
        check("mw_dec", 2, act, E_DEC_B);
        @(posedge clk); #1;
        #1;
        check("mw_adr", 3, act, E_MADR_S);
        @(posedge clk); #1;
        #1;
        check("mw_wr", 4, act, E_MEMWRITE);
        rst = 1'b1;
        #1;
        check("mw_cut", 4, act, E_RST);
        @(posedge clk);
        #1;
        check("mw_hold", 5, act, E_RST);
        rst = 1'b0;
        #1;
        check("rel_fch", 1, act, E_FETCH);
        @(posedge clk);
        #1;
        check("rel_dec", 2, act, E_DEC_B);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore-style finite-state controller that sequences the shared-ALU, single-memory multicycle RV32I datapath. It issues every mux select, write strobe, ALU function and immediate format per cycle, from the instruction-register fields (opc, f3, f7) and ALU flags (zero, neg) that the datapath returns. One instruction is in flight at a time; each occupies 3–5 cycles.

## Interface
- No parameters; encodings come from the shared package.
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opc  in  7  instr[6:0]
- f3  in  3  instr[14:12]
- f7  in  7  instr[31:25]
- zero  in  1  ALU result == 0
- neg  in  1  ALU result[31]
- PCWrite  out  1  PC load
- adrSrc  out  1  memory address: 0 PC, 1 Result
- memWrite  out  1  memory write
- IRWrite  out  1  IR and OldPC load
- regWrite  out  1  register-file write
- resultSrc  out  2  0 ALUOut, 1 Data, 2 ALUResult, 3 ImmExt
- ALUSrcA  out  2  0 PC, 1 OldPC, 2 A, 3 zero
- ALUSrcB  out  2  0 B, 1 ImmExt, 2 constant 4, 3 zero
- ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 101 XOR
- immSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U

## Operation
- Default for every output is 0 (ADD, I-imm, all strobes low). Each state overrides only the outputs listed.
- FETCH: IRWrite=1, ALUSrcB=2, resultSrc=2, PCWrite=1. Next state is DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=1; immSrc=J if opc=1101111, else B. ALUOut captures the branch/jal target.
  - Next state: lw/sw (0000011/0100011) → MEMADR; R 0110011 → EXECR; I 0010011 → EXECI; B 1100011 → BRANCH; jal 1101111 → JAL; jalr 1100111 → JALRADR; lui 0110111 → LUI.
  - Any other opcode → FETCH, executed as a NOP with no writes.
- MEMADR: ALUSrcA=2, ALUSrcB=1, immSrc=S for sw else I. Next is MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: adrSrc=1. Next state is MEMWB.
- MEMWB: resultSrc=1, regWrite=1. Next state is FETCH.
- MEMWRITE: adrSrc=1, memWrite=1. Next state is FETCH.
- EXECR: ALUSrcA=2, ALUControl from alu decoder. Next state is ALUWB.
- EXECI: ALUSrcA=2, ALUSrcB=1, ALUControl from alu decoder. Next state is ALUWB.
- ALUWB: regWrite=1. Next state is FETCH.
- BRANCH: ALUSrcA=2, SUB; PCWrite=taken.
  - taken is: f3 000 zero; 001 !zero; 100 neg; 101 !neg; other f3 0.
  - Next state is FETCH.
- JALRADR: ALUSrcA=2, ALUSrcB=1, immSrc=I. Next state is JAL.
- JAL: PCWrite=1 loads PC from ALUOut; ALUSrcA=1, ALUSrcB=2, so ALUOut captures OldPC+4. Next state is ALUWB.
- LUI: immSrc=U, resultSrc=3, regWrite=1. Next state is FETCH.
- ALU decoder:
  - f3=000 → SUB only if R-type and f7[5]=1, else ADD.
  - f3=111 AND, 110 OR, 010 SLT, 100 XOR.
  - Any other f3 → ADD.

## Timing
- rst asserted sets the state to FETCH asynchronously. While rst=1, PCWrite, IRWrite, regWrite and memWrite are forced 0; the selects show FETCH values.
- The first fetch occurs on the first rising edge after rst deasserts.
- All outputs are combinational from the state register plus opc/f3/f7. PCWrite in BRANCH also depends on zero/neg, which are valid within the same cycle.
- Cycles per instruction, FETCH inclusive:
  - lw 5, jalr 5
  - sw 4, R 4, I 4, jal 4
  - branch 3, lui 3, unknown 2
- Exactly one IRWrite pulse per instruction. At most one PCWrite after FETCH, and zero for not-taken branches.
- rst mid-instruction aborts with no partial write after the asserting edge. Any memWrite/regWrite pulse is cut combinationally.
- An unused state encoding → FETCH on the next edge.

## Structure
- Package riscv_ctrl_pkg holds:
  - opcode constants
  - the state enum
  - ALUControl, immSrc, resultSrc, ALUSrcA and ALUSrcB encodings.
- Sub-module alu_decoder holds the combinational f3/f7/instruction-class → ALUControl map. It is instantiated once.
- Main FSM consists of a state register, a next-state process and an output process.

## Test plan
- **Reset:** rst high mid-MEMWRITE → memWrite drops immediately. Release → FETCH with IRWrite=PCWrite=1 on the first cycle.
- **Loads and stores:** lw (opc 0000011) → state trace FETCH, DECODE, MEMADR, MEMREAD, MEMWB, with regWrite only in cycle 5 and resultSrc=1. sw → memWrite=1 in cycle 4 only, adrSrc=1.
- **R-type ALU map:** f3=000 with f7=0100000 → SUB; f7=0 → ADD; f3=111 → AND; f3=010 → SLT. I-type f3=000 with f7[5]=1 → still ADD.
- **beq (f3 000):** zero=1 → PCWrite=1 in cycle 3, resultSrc=0. zero=0 → PCWrite=0. bge with neg=0 → taken.
- **Jumps:** jal → DECODE immSrc=J, JAL PCWrite=1, ALUWB regWrite=1. jalr → 5 cycles with JALRADR immSrc=I.
- **lui and unknown opcodes:** lui → regWrite with resultSrc=3, immSrc=U in cycle 3. Opcode 1111111 → back to FETCH after DECODE, with no write strobe.
